// File: rtl/tt6581_pkg.sv
// Shared TT6581 definitions used by the multiplier arbiter.
package tt6581_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    MULT_ARB_IDLE  = 2'd0,
    MULT_ARB_ISSUE = 2'd1,
    MULT_ARB_WAIT  = 2'd2,
    MULT_ARB_RESP  = 2'd3
  } mult_arb_state_e;

  // Requester indices into the arbiter request vector.
  localparam int MULT_REQ_ENV = 0;
  localparam int MULT_REQ_SVF = 1;
  localparam int MULT_REQ_VOL = 2;

  // Round-robin successor of a grant index, wrapping at num_req.
  function automatic int rr_next(input int grant, input int num_req);
    return (grant + 1 >= num_req) ? 0 : grant + 1;
  endfunction

endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after ptr.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [PW-1:0]      grant,
  output logic               valid
);

  int idx;

  // Scan NUM_REQ positions starting at ptr and keep the first set bit.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      if (!valid && req[idx]) begin
        valid = 1'b1;
        grant = PW'(idx);
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one iterative multiplier between the envelope,
// SVF and volume stages, with a watchdog that aborts a stalled multiply.
module mult_arbiter
  import tt6581_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*WIDTH-1:0] op_a_i,
  input  logic [NUM_REQ*WIDTH-1:0] op_b_i,
  output logic [NUM_REQ-1:0]       done_o,
  output logic                     err_o,
  output logic [2*WIDTH-1:0]       result_o,
  output logic                     busy_o,
  output logic                     mult_start_o,
  output logic [WIDTH-1:0]         mult_a_o,
  output logic [WIDTH-1:0]         mult_b_o,
  input  logic                     mult_ready_i,
  input  logic [2*WIDTH-1:0]       mult_result_i
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0]      CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  mult_arb_state_e    state_r;
  logic [PW-1:0]      rr_ptr_r;
  logic [PW-1:0]      grant_r;
  logic [CW-1:0]      cnt_r;
  logic [NUM_REQ-1:0] done_r;
  logic               err_r;
  logic [2*WIDTH-1:0] result_r;
  logic               start_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;

  logic [PW-1:0]      pick_grant_s;
  logic               pick_valid_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr_pick (
    .req   (req_i),
    .ptr   (rr_ptr_r),
    .grant (pick_grant_s),
    .valid (pick_valid_s)
  );

  // Arbitration FSM; every output is a register written here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= MULT_ARB_IDLE;
      rr_ptr_r <= '0;
      grant_r  <= '0;
      cnt_r    <= '0;
      done_r   <= '0;
      err_r    <= 1'b0;
      result_r <= '0;
      start_r  <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
    end else begin
      // Pulse outputs default low and are raised for exactly one cycle.
      start_r <= 1'b0;
      done_r  <= '0;
      err_r   <= 1'b0;
      case (state_r)
        MULT_ARB_IDLE: begin
          if (pick_valid_s) begin
            state_r  <= MULT_ARB_ISSUE;
            grant_r  <= pick_grant_s;
            a_r      <= op_a_i[int'(pick_grant_s)*WIDTH +: WIDTH];
            b_r      <= op_b_i[int'(pick_grant_s)*WIDTH +: WIDTH];
            rr_ptr_r <= PW'(rr_next(int'(pick_grant_s), NUM_REQ));
            start_r  <= 1'b1;
          end else begin
            state_r <= MULT_ARB_IDLE;
          end
        end
        MULT_ARB_ISSUE: begin
          state_r <= MULT_ARB_WAIT;
          cnt_r   <= '0;
        end
        MULT_ARB_WAIT: begin
          // A ready arriving on the last watchdog cycle still counts as success.
          if (mult_ready_i) begin
            state_r  <= MULT_ARB_RESP;
            result_r <= mult_result_i;
            done_r   <= ONE_HOT0 << grant_r;
            err_r    <= 1'b0;
          end else if (cnt_r == CNT_LAST) begin
            state_r  <= MULT_ARB_RESP;
            result_r <= '0;
            done_r   <= ONE_HOT0 << grant_r;
            err_r    <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        MULT_ARB_RESP: begin
          state_r <= MULT_ARB_IDLE;
        end
        default: begin
          state_r <= MULT_ARB_IDLE;
        end
      endcase
    end
  end

  assign done_o       = done_r;
  assign err_o        = err_r;
  assign result_o     = result_r;
  assign busy_o       = (state_r != MULT_ARB_IDLE);
  assign mult_start_o = start_r;
  assign mult_a_o     = a_r;
  assign mult_b_o     = b_r;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed self-checking bench for mult_arbiter: a default-timeout instance
// for arbitration/reset cases and a TIMEOUT=8 instance for watchdog cases.
module tb_mult_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  // Main instance (TIMEOUT = 64)
  logic [2:0]  req;
  logic [47:0] op_a, op_b;
  logic [2:0]  done;
  logic        err, busy, start;
  logic [31:0] result;
  logic [15:0] ma, mb;
  logic        rdy;
  logic [31:0] mres;

  // Watchdog instance (TIMEOUT = 8)
  logic [2:0]  req8;
  logic [47:0] op_a8, op_b8;
  logic [2:0]  done8;
  logic        err8, busy8, start8;
  logic [31:0] result8;
  logic [15:0] ma8, mb8;
  logic        rdy8;
  logic [31:0] mres8;

  int errors = 0;
  int checks = 0;
  int lat;

  always #5 clk = ~clk;

  mult_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .op_a_i(op_a), .op_b_i(op_b),
    .done_o(done), .err_o(err), .result_o(result), .busy_o(busy),
    .mult_start_o(start), .mult_a_o(ma), .mult_b_o(mb),
    .mult_ready_i(rdy), .mult_result_i(mres)
  );

  mult_arbiter #(.TIMEOUT(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req8), .op_a_i(op_a8), .op_b_i(op_b8),
    .done_o(done8), .err_o(err8), .result_o(result8), .busy_o(busy8),
    .mult_start_o(start8), .mult_a_o(ma8), .mult_b_o(mb8),
    .mult_ready_i(rdy8), .mult_result_i(mres8)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From an IDLE cycle with a request pending: issue, wait k WAIT cycles,
  // answer with prod, and check the RESP cycle. Returns in the RESP cycle.
  task automatic run_op(input string tag, input int k, input logic [31:0] prod,
                        input logic [2:0] exp_done, input logic [15:0] exp_a,
                        input logic [15:0] exp_b);
    step();
    check_eq({tag, " start"}, 64'(start), 64'(1'b1));
    check_eq({tag, " a"}, 64'(ma), 64'(exp_a));
    check_eq({tag, " b"}, 64'(mb), 64'(exp_b));
    step();
    check_eq({tag, " start_low"}, 64'(start), 64'(1'b0));
    repeat (k) step();
    rdy  = 1'b1;
    mres = prod;
    step();
    rdy  = 1'b0;
    mres = 32'h0;
    check_eq({tag, " done"}, 64'(done), 64'(exp_done));
    check_eq({tag, " result"}, 64'(result), 64'(prod));
    check_eq({tag, " err"}, 64'(err), 64'(1'b0));
  endtask

  initial begin
    rst_n = 1'b0;
    req = 3'b000; op_a = 48'h0; op_b = 48'h0; rdy = 1'b0; mres = 32'h0;
    req8 = 3'b000; op_a8 = 48'h0; op_b8 = 48'h0; rdy8 = 1'b0; mres8 = 32'h0;
    repeat (3) step();

    // Reset state
    check_eq("rst done", 64'(done), 64'(3'b000));
    check_eq("rst busy", 64'(busy), 64'(1'b0));
    check_eq("rst start", 64'(start), 64'(1'b0));
    check_eq("rst result", 64'(result), 64'(32'h0));
    check_eq("rst a", 64'(ma), 64'(16'h0));

    // Contention: all three requesting from reset -> 0, 1, 2, 0
    req  = 3'b111;
    op_a = {16'h0033, 16'h0022, 16'h0011};
    op_b = {16'h0002, 16'h0002, 16'h0002};
    rst_n = 1'b1;
    run_op("rr0", 0, 32'h00000022, 3'b001, 16'h0011, 16'h0002);
    step();
    run_op("rr1", 1, 32'h00000044, 3'b010, 16'h0022, 16'h0002);
    step();
    run_op("rr2", 2, 32'h00000066, 3'b100, 16'h0033, 16'h0002);
    step();
    run_op("rr3", 0, 32'h00000022, 3'b001, 16'h0011, 16'h0002);
    req = 3'b000;
    step();
    check_eq("idle busy", 64'(busy), 64'(1'b0));
    check_eq("idle done", 64'(done), 64'(3'b000));

    // Single request: ready 17 cycles after start (16 WAIT cycles first)
    req  = 3'b001;
    op_a = {16'h0, 16'h0, 16'h0100};
    op_b = {16'h0, 16'h0, 16'h0200};
    run_op("single", 16, 32'h00020000, 3'b001, 16'h0100, 16'h0200);
    req = 3'b000;
    step();

    // Pointer wrap: grant 2, then 3'b101 gives 0 before 2
    req  = 3'b100;
    op_a = {16'h0007, 16'h0, 16'h0005};
    op_b = {16'h0003, 16'h0, 16'h0003};
    run_op("wrap2", 0, 32'h00000015, 3'b100, 16'h0007, 16'h0003);
    req = 3'b101;
    step();
    run_op("wrap0", 0, 32'h0000000F, 3'b001, 16'h0005, 16'h0003);
    step();
    run_op("wrap2b", 0, 32'h00000015, 3'b100, 16'h0007, 16'h0003);
    req = 3'b000;
    step();

    // Stray ready while IDLE is ignored
    rdy  = 1'b1;
    mres = 32'h00001234;
    step();
    rdy  = 1'b0;
    mres = 32'h0;
    check_eq("stray done", 64'(done), 64'(3'b000));
    check_eq("stray busy", 64'(busy), 64'(1'b0));

    // Timeout with TIMEOUT=8: done expected 10 cycles after request seen
    req8  = 3'b001;
    op_a8 = {16'h0, 16'h0, 16'h0005};
    op_b8 = {16'h0, 16'h0, 16'h0007};
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (done8 != 3'b000) begin
        lat = c;
        break;
      end
    end
    check_eq("to latency", 64'(lat), 64'(10));
    check_eq("to done", 64'(done8), 64'(3'b001));
    check_eq("to err", 64'(err8), 64'(1'b1));
    check_eq("to result", 64'(result8), 64'(32'h0));
    req8 = 3'b000;
    step();
    check_eq("to idle", 64'(busy8), 64'(1'b0));

    // Ready in the last watchdog cycle wins; signed -2 * 3
    req8  = 3'b010;
    op_a8 = {16'h0, 16'hFFFE, 16'h0};
    op_b8 = {16'h0, 16'h0003, 16'h0};
    step();                 // ISSUE (N+1)
    check_eq("sg start", 64'(start8), 64'(1'b1));
    check_eq("sg a", 64'(ma8), 64'(16'hFFFE));
    repeat (8) step();      // now N+9: counter at TIMEOUT-1
    check_eq("sg no early done", 64'(done8), 64'(3'b000));
    rdy8  = 1'b1;
    mres8 = 32'hFFFFFFFA;
    step();                 // RESP (N+10)
    rdy8  = 1'b0;
    mres8 = 32'h0;
    req8  = 3'b000;
    check_eq("sg done", 64'(done8), 64'(3'b010));
    check_eq("sg err", 64'(err8), 64'(1'b0));
    check_eq("sg result", 64'(result8), 64'(32'hFFFFFFFA));
    step();

    // Reset during WAIT of a grant to 1 (pointer then 2)
    req  = 3'b010;
    op_a = {16'h0033, 16'h0022, 16'h0011};
    op_b = {16'h0004, 16'h0004, 16'h0004};
    step();
    step();
    step();
    check_eq("pre-rst busy", 64'(busy), 64'(1'b1));
    rst_n = 1'b0;
    req   = 3'b000;
    step();
    check_eq("mid-rst busy", 64'(busy), 64'(1'b0));
    check_eq("mid-rst done", 64'(done), 64'(3'b000));
    check_eq("mid-rst a", 64'(ma), 64'(16'h0));
    check_eq("mid-rst b", 64'(mb), 64'(16'h0));
    check_eq("mid-rst start", 64'(start), 64'(1'b0));
    rst_n = 1'b1;
    rdy   = 1'b1;
    mres  = 32'h00000088;
    step();
    rdy  = 1'b0;
    mres = 32'h0;
    check_eq("late rdy done", 64'(done), 64'(3'b000));
    check_eq("late rdy busy", 64'(busy), 64'(1'b0));
    // Pointer back at 0: all requesting -> requester 0 first
    req = 3'b111;
    run_op("post-rst", 0, 32'h00000044, 3'b001, 16'h0011, 16'h0004);
    req = 3'b000;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
